// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage (with wb_stage_pkg)
// Purpose  : rv32imc writeback stage - load response capture, load alignment,
//            register-file write port, memory stall and RVFI retirement.
// Revision : 1.0 - initial release
// ============================================================================

package wb_stage_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] inst;
        logic [4:0]  rd_addr;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
    } rvfi_t;

    typedef struct packed {
        logic       regf_we;
        logic [1:0] wb_sel;
    } wb_ctrl_t;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [31:0] alu_out;
        logic [31:0] pc_next;
        wb_ctrl_t    wb_ctrl;
        rvfi_t       rvfi;
    } mem_stage_t;

endpackage

module wb_stage
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  mem_stage_t  mem_stage_reg,
    input  logic        pipe_stall,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output logic        regf_we,
    output logic [4:0]  regf_rd_addr,
    output logic [31:0] regf_wdata,
    output logic [63:0] retire_count,
    output logic        rvfi_valid,
    output logic [63:0] rvfi_order,
    output logic [31:0] rvfi_insn,
    output logic [4:0]  rvfi_rd_addr,
    output logic [31:0] rvfi_rd_wdata,
    output logic [31:0] rvfi_mem_rdata,
    output logic [31:0] rvfi_pc_rdata,
    output logic [31:0] rvfi_pc_wdata
);

    localparam logic [0:0] c_st_ready = 1'b0;
    localparam logic [0:0] c_st_hold  = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [31:0] r_hold_data;

    logic        w_valid;
    logic        w_acc;
    logic        w_ld;
    logic        w_commit;
    logic        w_use_hold;
    logic [31:0] w_raw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [2:0]  w_funct3;

    logic [63:0] r_retire_count;
    logic        r_rvfi_valid;
    logic [63:0] r_rvfi_order;
    logic [31:0] r_rvfi_insn;
    logic [4:0]  r_rvfi_rd_addr;
    logic [31:0] r_rvfi_rd_wdata;
    logic [31:0] r_rvfi_mem_rdata;
    logic [31:0] r_rvfi_pc_rdata;
    logic [31:0] r_rvfi_pc_wdata;

    assign w_valid = mem_stage_reg.rvfi.valid;
    assign w_acc   = w_valid & ((|mem_stage_reg.rvfi.mem_rmask) | (|mem_stage_reg.rvfi.mem_wmask));
    assign w_ld    = w_acc & (|mem_stage_reg.rvfi.mem_rmask);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_ready;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_ready: if (dmem_resp && w_acc && pipe_stall) w_state_next = c_st_hold;
            c_st_hold:  if (!pipe_stall)                      w_state_next = c_st_ready;
            default:                                          w_state_next = c_st_ready;
        endcase
    end

    always_comb begin
        mem_stall  = 1'b0;
        w_use_hold = 1'b0;
        case (r_state)
            c_st_ready: mem_stall  = w_acc & ~dmem_resp;
            c_st_hold:  w_use_hold = 1'b1;
            default:    mem_stall  = 1'b0;
        endcase
    end

    // A response that lands while the pipe is frozen must survive until release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_data <= 32'd0;
        end else if ((r_state == c_st_ready) && (w_state_next == c_st_hold)) begin
            r_hold_data <= dmem_rdata;
        end
    end

    assign w_commit = w_valid & ~pipe_stall & ~mem_stall;
    assign w_raw    = w_use_hold ? r_hold_data : dmem_rdata;
    assign w_funct3 = mem_stage_reg.rvfi.inst[14:12];

    always_comb begin
        case (mem_stage_reg.alu_out[1:0])
            2'd0:    w_byte = w_raw[7:0];
            2'd1:    w_byte = w_raw[15:8];
            2'd2:    w_byte = w_raw[23:16];
            default: w_byte = w_raw[31:24];
        endcase
        w_half = mem_stage_reg.alu_out[1] ? w_raw[31:16] : w_raw[15:0];
    end

    always_comb begin
        case (w_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_raw;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    always_comb begin
        case (mem_stage_reg.wb_ctrl.wb_sel)
            2'b00:   regf_wdata = mem_stage_reg.alu_out;
            2'b01:   regf_wdata = w_load;
            2'b10:   regf_wdata = mem_stage_reg.pc_next;
            default: regf_wdata = 32'd0;
        endcase
    end

    assign regf_we      = w_commit & mem_stage_reg.wb_ctrl.regf_we & (mem_stage_reg.rd_addr != 5'd0);
    assign regf_rd_addr = mem_stage_reg.rd_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retire_count   <= 64'd0;
            r_rvfi_valid     <= 1'b0;
            r_rvfi_order     <= 64'd0;
            r_rvfi_insn      <= 32'd0;
            r_rvfi_rd_addr   <= 5'd0;
            r_rvfi_rd_wdata  <= 32'd0;
            r_rvfi_mem_rdata <= 32'd0;
            r_rvfi_pc_rdata  <= 32'd0;
            r_rvfi_pc_wdata  <= 32'd0;
        end else begin
            r_rvfi_valid <= w_commit;
            if (w_commit) begin
                r_retire_count   <= r_retire_count + 64'd1;
                r_rvfi_order     <= mem_stage_reg.rvfi.order;
                r_rvfi_insn      <= mem_stage_reg.rvfi.inst;
                r_rvfi_rd_addr   <= mem_stage_reg.rvfi.rd_addr;
                r_rvfi_rd_wdata  <= (mem_stage_reg.rd_addr == 5'd0) ? 32'd0 : regf_wdata;
                r_rvfi_mem_rdata <= w_ld ? w_raw : 32'd0;
                r_rvfi_pc_rdata  <= mem_stage_reg.rvfi.pc_rdata;
                r_rvfi_pc_wdata  <= mem_stage_reg.rvfi.pc_wdata;
            end
        end
    end

    assign retire_count   = r_retire_count;
    assign rvfi_valid     = r_rvfi_valid;
    assign rvfi_order     = r_rvfi_order;
    assign rvfi_insn      = r_rvfi_insn;
    assign rvfi_rd_addr   = r_rvfi_rd_addr;
    assign rvfi_rd_wdata  = r_rvfi_rd_wdata;
    assign rvfi_mem_rdata = r_rvfi_mem_rdata;
    assign rvfi_pc_rdata  = r_rvfi_pc_rdata;
    assign rvfi_pc_wdata  = r_rvfi_pc_wdata;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Directed plus randomized bench for wb_stage against a reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    mem_stage_t  msr;
    logic        pipe_stall;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        mem_stall;
    logic        regf_we;
    logic [4:0]  regf_rd_addr;
    logic [31:0] regf_wdata;
    logic [63:0] retire_count;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_mem_rdata;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_pc_wdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] order_ctr = 64'd0;

    // reference model: a pending captured response and the last retired record
    logic        m_cap = 1'b0;
    logic [31:0] m_cap_data = 32'd0;
    logic [63:0] m_count = 64'd0;
    logic        m_rv_valid = 1'b0;
    logic [63:0] m_rv_order = 64'd0;
    logic [31:0] m_rv_insn = 32'd0;
    logic [4:0]  m_rv_rd_addr = 5'd0;
    logic [31:0] m_rv_rd_wdata = 32'd0;
    logic [31:0] m_rv_mem_rdata = 32'd0;
    logic [31:0] m_rv_pc_rdata = 32'd0;
    logic [31:0] m_rv_pc_wdata = 32'd0;

    logic        e_acc, e_ld, e_stall, e_commit, e_we;
    logic [31:0] e_raw, e_wdata;

    wb_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_stage_reg  (msr),
        .pipe_stall     (pipe_stall),
        .dmem_rdata     (dmem_rdata),
        .dmem_resp      (dmem_resp),
        .mem_stall      (mem_stall),
        .regf_we        (regf_we),
        .regf_rd_addr   (regf_rd_addr),
        .regf_wdata     (regf_wdata),
        .retire_count   (retire_count),
        .rvfi_valid     (rvfi_valid),
        .rvfi_order     (rvfi_order),
        .rvfi_insn      (rvfi_insn),
        .rvfi_rd_addr   (rvfi_rd_addr),
        .rvfi_rd_wdata  (rvfi_rd_wdata),
        .rvfi_mem_rdata (rvfi_mem_rdata),
        .rvfi_pc_rdata  (rvfi_pc_rdata),
        .rvfi_pc_wdata  (rvfi_pc_wdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_align(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
        logic [31:0] b;
        logic [31:0] h;
        b = word >> (8 * int'(off));
        h = word >> (16 * int'(off[1]));
        case (f3)
            3'd0:    return 32'(signed'(b[7:0]));
            3'd1:    return 32'(signed'(h[15:0]));
            3'd2:    return word;
            3'd4:    return b & 32'h0000_00FF;
            3'd5:    return h & 32'h0000_FFFF;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_eval();
        e_acc    = msr.rvfi.valid && ((msr.rvfi.mem_rmask != 0) || (msr.rvfi.mem_wmask != 0));
        e_ld     = e_acc && (msr.rvfi.mem_rmask != 0);
        e_stall  = e_acc && !m_cap && !dmem_resp;
        e_commit = msr.rvfi.valid && !pipe_stall && !e_stall;
        e_raw    = m_cap ? m_cap_data : dmem_rdata;
        case (msr.wb_ctrl.wb_sel)
            2'd0:    e_wdata = msr.alu_out;
            2'd1:    e_wdata = ref_align(msr.rvfi.inst[14:12], msr.alu_out[1:0], e_raw);
            2'd2:    e_wdata = msr.pc_next;
            default: e_wdata = 32'd0;
        endcase
        e_we = e_commit && msr.wb_ctrl.regf_we && (msr.rd_addr != 0);
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_cap = 0; m_cap_data = 0; m_count = 0;
            m_rv_valid = 0; m_rv_order = 0; m_rv_insn = 0; m_rv_rd_addr = 0;
            m_rv_rd_wdata = 0; m_rv_mem_rdata = 0; m_rv_pc_rdata = 0; m_rv_pc_wdata = 0;
        end else begin
            m_rv_valid = e_commit;
            if (e_commit) begin
                m_count        = m_count + 1;
                m_rv_order     = msr.rvfi.order;
                m_rv_insn      = msr.rvfi.inst;
                m_rv_rd_addr   = msr.rvfi.rd_addr;
                m_rv_rd_wdata  = (msr.rd_addr == 0) ? 32'd0 : e_wdata;
                m_rv_mem_rdata = e_ld ? e_raw : 32'd0;
                m_rv_pc_rdata  = msr.rvfi.pc_rdata;
                m_rv_pc_wdata  = msr.rvfi.pc_wdata;
            end
            if (m_cap) begin
                if (!pipe_stall) m_cap = 0;
            end else if (dmem_resp && e_acc && pipe_stall) begin
                m_cap      = 1;
                m_cap_data = dmem_rdata;
            end
        end
    endtask

    // Inputs are already driven; check combinational outputs, clock once, check registers.
    task automatic step();
        #1;
        model_eval();
        check_val("mem_stall",    64'(mem_stall),    64'(e_stall));
        check_val("regf_we",      64'(regf_we),      64'(e_we));
        check_val("regf_rd_addr", 64'(regf_rd_addr), 64'(msr.rd_addr));
        check_val("regf_wdata",   64'(regf_wdata),   64'(e_wdata));
        @(posedge clk);
        model_update();
        #1;
        check_val("retire_count",   retire_count,         m_count);
        check_val("rvfi_valid",     64'(rvfi_valid),      64'(m_rv_valid));
        check_val("rvfi_order",     rvfi_order,           m_rv_order);
        check_val("rvfi_insn",      64'(rvfi_insn),       64'(m_rv_insn));
        check_val("rvfi_rd_addr",   64'(rvfi_rd_addr),    64'(m_rv_rd_addr));
        check_val("rvfi_rd_wdata",  64'(rvfi_rd_wdata),   64'(m_rv_rd_wdata));
        check_val("rvfi_mem_rdata", 64'(rvfi_mem_rdata),  64'(m_rv_mem_rdata));
        check_val("rvfi_pc_rdata",  64'(rvfi_pc_rdata),   64'(m_rv_pc_rdata));
        check_val("rvfi_pc_wdata",  64'(rvfi_pc_wdata),   64'(m_rv_pc_wdata));
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 jal, 4 wb_sel=11, 5 bubble
    task automatic present(input int kind, input logic [4:0] rd, input logic [31:0] alu,
                           input logic [2:0] f3);
        logic [31:0] inst;
        logic [31:0] pc;
        inst = $urandom;
        inst[14:12] = f3;
        pc = $urandom & 32'hFFFF_FFFC;
        msr = '0;
        msr.rd_addr          = rd;
        msr.alu_out          = alu;
        msr.pc_next          = pc + 32'd4;
        msr.rvfi.valid       = (kind != 5);
        msr.rvfi.order       = order_ctr;
        msr.rvfi.inst        = inst;
        msr.rvfi.rd_addr     = rd;
        msr.rvfi.pc_rdata    = pc;
        msr.rvfi.pc_wdata    = pc + 32'd4;
        msr.wb_ctrl.regf_we  = (kind != 2);
        case (kind)
            1: begin msr.wb_ctrl.wb_sel = 2'b01; msr.rvfi.mem_rmask = 4'($urandom_range(1, 15)); end
            2: begin msr.wb_ctrl.wb_sel = 2'b00; msr.rvfi.mem_wmask = 4'($urandom_range(1, 15)); end
            3: msr.wb_ctrl.wb_sel = 2'b10;
            4: msr.wb_ctrl.wb_sel = 2'b11;
            default: msr.wb_ctrl.wb_sel = 2'b00;
        endcase
        order_ctr = order_ctr + 1;
    endtask

    task automatic present_random();
        logic [4:0] rd;
        rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
        present(int'($urandom_range(0, 5)), rd, $urandom, 3'($urandom));
    endtask

    initial begin
        rst_n = 1'b0; pipe_stall = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'd0; msr = '0;
        step();
        step();
        rst_n = 1'b1;

        // ALU result
        present(0, 5'd5, 32'h0000_1234, 3'd0);
        step();
        check_val("alu_rvfi_wdata", 64'(rvfi_rd_wdata), 64'h1234);
        check_val("alu_retire", retire_count, 64'd1);

        // Sign-extending load with late response
        present(1, 5'd7, 32'h1000_0002, 3'd0);
        dmem_rdata = 32'h0080_0000;
        repeat (3) step();
        dmem_resp = 1'b1;
        step();
        check_val("lb_wdata", 64'(regf_wdata), 64'hFFFF_FF80);
        check_val("lb_mem_rdata", 64'(rvfi_mem_rdata), 64'h0080_0000);

        // Zero-extending halfword
        present(1, 5'd8, 32'h2000_0002, 3'd5);
        dmem_rdata = 32'hBEEF_0000;
        step();
        check_val("lhu_rvfi_wdata", 64'(rvfi_rd_wdata), 64'h0000_BEEF);

        // Response while frozen
        present(1, 5'd9, 32'h3000_0000, 3'd2);
        pipe_stall = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        step();
        dmem_resp = 1'b0;
        repeat (2) begin dmem_rdata = $urandom; step(); end
        pipe_stall = 1'b0;
        step();
        check_val("frozen_wdata", 64'(rvfi_rd_wdata), 64'hCAFE_F00D);

        // x0 destination
        present(1, 5'd0, 32'h4000_0000, 3'd2);
        dmem_rdata = 32'h5; dmem_resp = 1'b1;
        step();
        check_val("x0_rvfi_wdata", 64'(rvfi_rd_wdata), 64'd0);

        // Reset while holding a response
        present(1, 5'd10, 32'h5000_0000, 3'd2);
        pipe_stall = 1'b1; dmem_rdata = 32'h1111_2222; dmem_resp = 1'b1;
        step();
        rst_n = 1'b0; dmem_resp = 1'b0;
        step();
        check_val("rst_retire", retire_count, 64'd0);
        rst_n = 1'b1; pipe_stall = 1'b0;
        step();
        check_val("rst_restall", 64'(mem_stall), 64'd1);
        dmem_resp = 1'b1; dmem_rdata = 32'h3333_4444;
        step();

        // Randomized traffic
        present_random();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            pipe_stall = ($urandom_range(0, 3) == 0);
            dmem_resp  = ($urandom_range(0, 2) == 0);
            dmem_rdata = $urandom;
            step();
            if (e_commit || !msr.rvfi.valid) present_random();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_stage.md
# wb_stage

Writeback pipeline stage of the rv32imc core. Sits directly downstream of `mem_stage` and consumes `mem_stage_reg`. It does the following:
- waits for the data-memory response of the instruction in writeback;
- aligns and sign/zero-extends load data;
- drives the register-file write port and forwarding tap;
- generates `mem_stall`;
- retires instructions onto the registered RVFI commit outputs and the retire counter.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `rst_n`  in  1  reset; one clock, synchronous, active-low
- `mem_stage_reg`  in  mem_stage_t  instruction in writeback. Fields used:
  - `rd_addr`, `alu_out`, `pc_next`
  - `wb_ctrl.regf_we`, `wb_ctrl.wb_sel[1:0]` (00 alu, 01 load, 10 pc_next)
  - `rvfi.*`
- `pipe_stall`  in  1  freeze from all sources other than this block
- `dmem_rdata`  in  32  word-aligned read data
- `dmem_resp`  in  1  single-cycle response pulse for the outstanding access
- `mem_stall`  out  1  outstanding access not yet answered
- `regf_we`  out  1  register-file write enable
- `regf_rd_addr`  out  5  destination register
- `regf_wdata`  out  32  writeback data (also the forwarding tap)
- `retire_count`  out  64  instructions retired since reset
- `rvfi_valid`  out  1  registered commit strobe
- `rvfi_order`  out  64  registered
- `rvfi_insn`  out  32  registered
- `rvfi_rd_addr`  out  5  registered
- `rvfi_rd_wdata`  out  32  registered
- `rvfi_mem_rdata`  out  32  registered
- `rvfi_pc_rdata`  out  32  registered
- `rvfi_pc_wdata`  out  32  registered

## Operation
Definitions:
- `valid` = `mem_stage_reg.rvfi.valid`
- `acc` = `valid` & (|`rvfi.mem_rmask` | |`rvfi.mem_wmask`)
- `ld` = `acc` & |`rvfi.mem_rmask`

Response FSM, two states:
- **READY**: no response captured.
  - `dmem_resp` & `acc` & `pipe_stall` -> capture `dmem_rdata` into `hold_data`; go to HOLD.
  - Otherwise stay in READY.
- **HOLD**: response captured while frozen.
  - `!pipe_stall` -> commit using `hold_data`; go to READY.
  - `dmem_resp` arriving in HOLD is ignored.
- `dmem_resp` with `!acc` is ignored in either state.

Stall and commit:
- `mem_stall` = `acc` & state==READY & `!dmem_resp`. This is combinational, same cycle.
- `commit` = `valid` & `!pipe_stall` & `!mem_stall`.
- Load data source: `dmem_rdata` in READY, `hold_data` in HOLD.

Load alignment:
- Byte offset `off` = `alu_out[1:0]`; funct3 = `rvfi.inst[14:12]`.
- lb/lbu: byte `off`, sign- or zero-extended.
- lh/lhu: halfword `off[1]`, sign- or zero-extended.
- lw: full word.
- Any other funct3 -> 0.

Write data and write enable:
- `regf_wdata` is selected by `wb_sel`: `alu_out`, aligned load, or `pc_next`; 11 -> 0.
- `regf_we` = `commit` & `wb_ctrl.regf_we` & (`rd_addr` != 0).
- `regf_rd_addr` = `rd_addr`.

Retire:
- On `commit`, `retire_count` increments by 1 and wraps modulo 2^64.
- The RVFI registers load from `mem_stage_reg.rvfi`.
- `rvfi_rd_wdata` = `regf_wdata`, or 0 when `rd_addr`==0.
- `rvfi_mem_rdata` = raw word used for the load, or 0 if `!ld`.
- With no commit, `rvfi_valid` <= 0 and the other RVFI registers hold.

Reset (`rst_n`=0):
- State -> READY; `hold_data`, `retire_count`, and all `rvfi_*` -> 0.
- A captured response is discarded, including when reset lands mid-HOLD.
- Combinational outputs follow the inputs; upstream reset clears `valid`, so `regf_we`=0 and `mem_stall`=0.

## Timing
- Commit in cycle N with no memory access: RVFI strobe at N+1.
- Load with `dmem_resp` in cycle N and `!pipe_stall`: register write in cycle N, RVFI at N+1.
- Response in a frozen cycle N: data held from N+1.
  - Commit in the first cycle with `pipe_stall`=0; `mem_stall` stays 0 throughout.
- Back-to-back loads: the next instruction enters the cycle after commit; state is READY.
  - Its `mem_stall` asserts until its own `dmem_resp`.

## Test plan
- **ALU result**: `addi` with `alu_out`=0x0000_1234, rd=5, `wb_sel`=00, no stalls.
  - `regf_we`=1, `regf_wdata`=0x1234 in the same cycle.
  - Next cycle: `rvfi_valid`=1, `rvfi_rd_wdata`=0x1234, `retire_count`=1.
- **Sign-extending load**: lb, `alu_out[1:0]`=2, `dmem_rdata`=0x0080_0000, `dmem_resp` 3 cycles later.
  - `mem_stall`=1 for 3 cycles.
  - Then `regf_wdata`=0xFFFF_FF80, and `rvfi_mem_rdata`=0x0080_0000 on the following cycle.
- **Zero-extending load**: lhu, `alu_out[1:0]`=2, `dmem_rdata`=0xBEEF_0000.
  - `regf_wdata`=0x0000_BEEF.
- **Response while frozen**: `dmem_resp` with `dmem_rdata`=0xCAFEF00D while `pipe_stall`=1, then `pipe_stall` held 2 more cycles while `dmem_rdata` changes.
  - `regf_we` is held 0 and `mem_stall`=0 throughout.
  - Commit on release with `regf_wdata`=0xCAFEF00D.
- **x0 destination**: load to rd=0 with `dmem_rdata`=0x5.
  - `regf_we`=0, `rvfi_rd_wdata`=0, `retire_count` increments.
- **Reset during HOLD**: `rst_n`=0 in HOLD.
  - Next cycle: state READY, `rvfi_valid`=0, `retire_count`=0.
  - Re-presenting the load requires a new `dmem_resp` (`mem_stall`=1 until it arrives).
